// File: rtl/frac_div_pkg.sv
// Shared types, reset defaults and config validation for the fractional clock divider.
package frac_div_pkg;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  // Reset ratio 8 + 7/10 = 8.7 input cycles per output cycle.
  localparam int unsigned DEF_INT = 8;
  localparam int unsigned DEF_NUM = 7;
  localparam int unsigned DEF_DEN = 10;

  // A ratio is usable when N >= 2, DEN != 0 and NUM < DEN.
  function automatic logic cfg_valid(input logic [31:0] n,
                                     input logic [31:0] num,
                                     input logic [31:0] den);
    return (n >= 32'd2) && (den != '0) && (num < den);
  endfunction

endpackage

// File: rtl/frac_div_acc.sv
// First-order phase accumulator choosing between N and N+1 cycle periods.
module frac_div_acc
  import frac_div_pkg::*;
#(
  parameter int unsigned W_FRAC = 8
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic [W_FRAC-1:0] num,
  input  logic [W_FRAC-1:0] den,
  input  logic              step,
  input  logic              clear,
  output logic              long_period
);

  logic [W_FRAC-1:0] acc;
  logic [W_FRAC-1:0] acc_base;
  logic [W_FRAC-1:0] acc_next;
  logic [W_FRAC:0]   sum;

  // Clear zeroes the accumulator before the sum, so a fresh ratio starts at phase 0.
  always_comb begin
    acc_base    = clear ? '0 : acc;
    sum         = {1'b0, acc_base} + {1'b0, num};
    long_period = (sum >= {1'b0, den});
    acc_next    = long_period ? W_FRAC'(sum - {1'b0, den}) : sum[W_FRAC-1:0];
  end

  // Advance on each period start; a clear without a start just zeroes the phase.
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      acc <= '0;
    end else if (step) begin
      acc <= acc_next;
    end else if (clear) begin
      acc <= '0;
    end
  end

endmodule

// File: rtl/frac_clk_div.sv
// Runtime-programmable dual-modulus fractional clock divider with shadowed config.
module frac_clk_div #(
  parameter int unsigned W_INT   = 8,
  parameter int unsigned W_FRAC  = 8,
  parameter int unsigned DEF_INT = frac_div_pkg::DEF_INT,
  parameter int unsigned DEF_NUM = frac_div_pkg::DEF_NUM,
  parameter int unsigned DEF_DEN = frac_div_pkg::DEF_DEN
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic              en,
  input  logic [W_INT-1:0]  cfg_int,
  input  logic [W_FRAC-1:0] cfg_num,
  input  logic [W_FRAC-1:0] cfg_den,
  input  logic              cfg_load,
  output logic              cfg_ack,
  output logic              cfg_err,
  output logic              clk_out,
  output logic              period_start
);

  import frac_div_pkg::*;

  localparam int unsigned W_CNT = W_INT + 1;

  state_t            state, state_next;
  logic [W_INT-1:0]  act_int, pend_int, eff_int;
  logic [W_FRAC-1:0] act_num, pend_num, eff_num;
  logic [W_FRAC-1:0] act_den, pend_den, eff_den;
  logic              pend_v;
  logic [W_CNT-1:0]  cnt, cnt_inc, len, len_new, half;
  logic              at_end, apply, start, long_period, load_ok;

  assign load_ok = cfg_valid(32'(cfg_int), 32'(cfg_num), 32'(cfg_den));
  assign at_end  = (state == RUN) && (cnt == len - W_CNT'(1));
  assign cnt_inc = cnt + W_CNT'(1);
  assign half    = len >> 1;

  // A config applied on this edge is already in force for the period it starts.
  assign eff_int = apply ? pend_int : act_int;
  assign eff_num = apply ? pend_num : act_num;
  assign eff_den = apply ? pend_den : act_den;
  assign len_new = {1'b0, eff_int} + W_CNT'(long_period);

  frac_div_acc #(
    .W_FRAC(W_FRAC)
  ) u_acc (
    .clk_in     (clk_in),
    .rst        (rst),
    .num        (eff_num),
    .den        (eff_den),
    .step       (start),
    .clear      (apply),
    .long_period(long_period)
  );

  // State register.
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Config swaps and run/stop decisions happen only in IDLE or on a period boundary.
  always_comb begin
    state_next = state;
    apply      = 1'b0;
    start      = 1'b0;
    case (state)
      IDLE: begin
        apply = pend_v;
        if (en) begin
          start      = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (at_end) begin
          apply = pend_v;
          if (en) start      = 1'b1;
          else    state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Active/pending config shadow; a new valid load wins over an applying one.
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      act_int  <= W_INT'(DEF_INT);
      act_num  <= W_FRAC'(DEF_NUM);
      act_den  <= W_FRAC'(DEF_DEN);
      pend_int <= '0;
      pend_num <= '0;
      pend_den <= '0;
      pend_v   <= 1'b0;
      cfg_ack  <= 1'b0;
      cfg_err  <= 1'b0;
    end else begin
      cfg_ack <= apply;
      cfg_err <= cfg_load && !load_ok;
      if (apply) begin
        act_int <= pend_int;
        act_num <= pend_num;
        act_den <= pend_den;
      end
      if (cfg_load && load_ok) begin
        pend_int <= cfg_int;
        pend_num <= cfg_num;
        pend_den <= cfg_den;
        pend_v   <= 1'b1;
      end else if (apply) begin
        pend_v <= 1'b0;
      end
    end
  end

  // Period counter and output waveform: high for L>>1 cycles, then low.
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      cnt          <= '0;
      len          <= '0;
      clk_out      <= 1'b0;
      period_start <= 1'b0;
    end else if (start) begin
      cnt          <= '0;
      len          <= len_new;
      clk_out      <= 1'b1;
      period_start <= 1'b1;
    end else begin
      period_start <= 1'b0;
      if ((state == RUN) && !at_end) begin
        cnt     <= cnt_inc;
        clk_out <= (cnt_inc < half);
      end else begin
        clk_out <= 1'b0;
      end
    end
  end

endmodule
